// File: rtl/cpu_types_pkg.sv
// Shared A0 pipeline types: register index width and hazard controller states.
package cpu_types_pkg;
  localparam int REGW = 5;
  typedef logic [REGW-1:0] regbits_t;
  typedef enum logic [1:0] {RUN, LDUSE, MEMWAIT, HALT} hzstate_t;
endpackage

// File: rtl/hazard_unit_if.sv
// Bundle of hazard controller signals, with the controller-side and bench-side views.
interface hazard_unit_if #(parameter int PERFW = 32);
  import cpu_types_pkg::*;
  logic ihit, dhit, xmem_ren, xmem_wen, xmem_halt;
  logic idex_memread, ifid_uses_rt, branch, branch_neq, is_equal, jump;
  regbits_t idex_rd, ifid_rs, ifid_rt;
  logic pc_en, take_branch;
  logic stall_ifid, stall_idex, stall_xmem, stall_wb;
  logic flush_ifid, flush_idex, flush_xmem, flush_wb;
  logic [PERFW-1:0] stall_count;

  modport hzu (
    input  ihit, dhit, xmem_ren, xmem_wen, xmem_halt, idex_memread, idex_rd,
           ifid_rs, ifid_rt, ifid_uses_rt, branch, branch_neq, is_equal, jump,
    output pc_en, take_branch, stall_ifid, stall_idex, stall_xmem, stall_wb,
           flush_ifid, flush_idex, flush_xmem, flush_wb, stall_count
  );

  modport tb (
    output ihit, dhit, xmem_ren, xmem_wen, xmem_halt, idex_memread, idex_rd,
           ifid_rs, ifid_rt, ifid_uses_rt, branch, branch_neq, is_equal, jump,
    input  pc_en, take_branch, stall_ifid, stall_idex, stall_xmem, stall_wb,
           flush_ifid, flush_idex, flush_xmem, flush_wb, stall_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stateful hazard controller for the 5-stage pipeline: sequences load-use bubbles,
// data-cache-miss waits and halt, and drives per-stage stall/flush and PC enable.
module hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int REGW      = cpu_types_pkg::REGW,
  parameter int LU_STALLS = 1,
  parameter int PERFW     = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             xmem_ren,
  input  logic             xmem_wen,
  input  logic             xmem_halt,
  input  logic             idex_memread,
  input  logic [REGW-1:0]  idex_rd,
  input  logic [REGW-1:0]  ifid_rs,
  input  logic [REGW-1:0]  ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             branch,
  input  logic             branch_neq,
  input  logic             is_equal,
  input  logic             jump,
  output logic             pc_en,
  output logic             stall_ifid,
  output logic             stall_idex,
  output logic             stall_xmem,
  output logic             stall_wb,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_xmem,
  output logic             flush_wb,
  output logic             take_branch,
  output logic [PERFW-1:0] stall_count
);

  localparam int CW = $clog2(LU_STALLS + 1);

  hzstate_t         state_reg, state_next, eff_state;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [PERFW-1:0] stall_count_reg;
  logic             lu_hit, mem_busy, branch_taken;

  assign lu_hit = idex_memread && (idex_rd != '0) &&
                  ((idex_rd == ifid_rs) || (ifid_uses_rt && (idex_rd == ifid_rt)));
  assign mem_busy     = (xmem_ren || xmem_wen) && !dhit;
  assign branch_taken = branch && (is_equal ^ branch_neq);
  assign stall_count  = stall_count_reg;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg       <= RUN;
      cnt_reg         <= '0;
      stall_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (!pc_en && (state_reg != HALT))
        stall_count_reg <= stall_count_reg + PERFW'(1);
    end
  end

  always_comb begin
    pc_en       = 1'b1;
    stall_ifid  = 1'b0;
    stall_idex  = 1'b0;
    stall_xmem  = 1'b0;
    stall_wb    = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_xmem  = 1'b0;
    flush_wb    = 1'b0;
    take_branch = branch_taken;
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    // Leaving MEMWAIT resumes whatever was deferred, including an unfinished bubble.
    eff_state   = state_reg;
    if (state_reg == MEMWAIT)
      eff_state = (cnt_reg != '0) ? LDUSE : RUN;

    if (!nRST) begin
      pc_en       = 1'b0;
      flush_ifid  = 1'b1;
      flush_idex  = 1'b1;
      flush_xmem  = 1'b1;
      flush_wb    = 1'b1;
      take_branch = 1'b0;
      state_next  = RUN;
      cnt_next    = '0;
    end else if (state_reg == HALT) begin
      pc_en      = 1'b0;
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
      flush_xmem = 1'b1;
    end else if (mem_busy) begin
      pc_en      = 1'b0;
      stall_ifid = 1'b1;
      stall_idex = 1'b1;
      stall_xmem = 1'b1;
      flush_wb   = 1'b1;
      state_next = MEMWAIT;
    end else if (xmem_halt) begin
      pc_en      = 1'b0;
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
      flush_xmem = 1'b1;
      state_next = HALT;
    end else if (branch_taken) begin
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
      cnt_next   = '0;
      state_next = RUN;
    end else if (jump) begin
      flush_ifid = 1'b1;
      state_next = eff_state;
    end else if ((eff_state == LDUSE) || lu_hit) begin
      pc_en      = 1'b0;
      stall_ifid = 1'b1;
      flush_idex = 1'b1;
      if (eff_state == LDUSE) begin
        cnt_next   = cnt_reg - CW'(1);
        state_next = (cnt_reg == CW'(1)) ? RUN : LDUSE;
      end else if (LU_STALLS > 1) begin
        cnt_next   = CW'(LU_STALLS - 1);
        state_next = LDUSE;
      end else begin
        state_next = RUN;
      end
    end else begin
      state_next = RUN;
      if (!ihit) begin
        pc_en      = 1'b0;
        flush_ifid = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (LU_STALLS=2): directed vectors push expected
// outputs into a queue; a monitor pops and compares every falling edge.
module tb_hazard_ctrl;
  localparam int REGW  = 5;
  localparam int PERFW = 32;

  logic CLK = 1'b0;
  logic nRST;
  logic ihit, dhit, xmem_ren, xmem_wen, xmem_halt, idex_memread, ifid_uses_rt;
  logic branch, branch_neq, is_equal, jump;
  logic [REGW-1:0] idex_rd, ifid_rs, ifid_rt;
  logic pc_en, take_branch;
  logic stall_ifid, stall_idex, stall_xmem, stall_wb;
  logic flush_ifid, flush_idex, flush_xmem, flush_wb;
  logic [PERFW-1:0] stall_count;

  hazard_ctrl #(.REGW(REGW), .LU_STALLS(2), .PERFW(PERFW)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .xmem_ren(xmem_ren), .xmem_wen(xmem_wen), .xmem_halt(xmem_halt),
    .idex_memread(idex_memread), .idex_rd(idex_rd), .ifid_rs(ifid_rs),
    .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt), .branch(branch),
    .branch_neq(branch_neq), .is_equal(is_equal), .jump(jump),
    .pc_en(pc_en), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
    .stall_xmem(stall_xmem), .stall_wb(stall_wb), .flush_ifid(flush_ifid),
    .flush_idex(flush_idex), .flush_xmem(flush_xmem), .flush_wb(flush_wb),
    .take_branch(take_branch), .stall_count(stall_count)
  );

  always #5 CLK = ~CLK;

  // {pc_en, stall ifid/idex/xmem/wb, flush ifid/idex/xmem/wb, take_branch}
  localparam logic [9:0] O_RST   = 10'b0_0000_1111_0;
  localparam logic [9:0] O_RUN   = 10'b1_0000_0000_0;
  localparam logic [9:0] O_LU    = 10'b0_1000_0100_0;
  localparam logic [9:0] O_JUMP  = 10'b1_0000_1000_0;
  localparam logic [9:0] O_BR    = 10'b1_0000_1100_1;
  localparam logic [9:0] O_NOI   = 10'b0_0000_1000_0;
  localparam logic [9:0] O_MWBR  = 10'b0_1110_0001_1;
  localparam logic [9:0] O_MW    = 10'b0_1110_0001_0;
  localparam logic [9:0] O_HALT  = 10'b0_0000_1110_0;

  typedef struct {
    logic [9:0]       o;
    logic [PERFW-1:0] sc;
    int               id;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int fails  = 0;
  int vid    = 0;
  logic [PERFW-1:0] exp_sc = '0;

  task automatic next_cycle();
    @(posedge CLK);
    #1;
    ihit = 1'b1; dhit = 1'b0; xmem_ren = 1'b0; xmem_wen = 1'b0; xmem_halt = 1'b0;
    idex_memread = 1'b0; idex_rd = '0; ifid_rs = '0; ifid_rt = '0; ifid_uses_rt = 1'b0;
    branch = 1'b0; branch_neq = 1'b0; is_equal = 1'b0; jump = 1'b0;
  endtask

  // Queue the expected response; the stall counter shows its pre-edge value this cycle.
  task automatic expect_vec(input logic [9:0] o, input bit no_count);
    exp_t e;
    e.o = o; e.sc = exp_sc; e.id = vid;
    q.push_back(e);
    vid++;
    if (!no_count && !o[9]) exp_sc = exp_sc + 1;
  endtask

  task automatic load_use(input logic [REGW-1:0] rd, input logic [REGW-1:0] rs);
    idex_memread = 1'b1; idex_rd = rd; ifid_rs = rs;
  endtask

  initial begin : monitor
    exp_t e;
    logic [9:0] act;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        act = {pc_en, stall_ifid, stall_idex, stall_xmem, stall_wb,
               flush_ifid, flush_idex, flush_xmem, flush_wb, take_branch};
        checks++;
        if (act !== e.o) begin
          fails++;
          $display("FAIL outputs vec%0d: got %b expected %b", e.id, act, e.o);
        end
        checks++;
        if (stall_count !== e.sc) begin
          fails++;
          $display("FAIL stall_count vec%0d: got %0d expected %0d", e.id, stall_count, e.sc);
        end
        $display("vec%0d outs=%b stall_count=%0d", e.id, act, stall_count);
      end
    end
  end

  initial begin : driver
    nRST = 1'b0;
    next_cycle();
    expect_vec(O_RST, 1'b1);                          // reset state
    next_cycle(); nRST = 1'b1; expect_vec(O_RUN, 0);  // idle
    next_cycle(); load_use(5'd8, 5'd8); expect_vec(O_LU, 0);
    next_cycle(); expect_vec(O_LU, 0);                // second bubble from LDUSE
    next_cycle(); expect_vec(O_RUN, 0);               // released, stall_count=2
    next_cycle(); load_use(5'd0, 5'd0); expect_vec(O_RUN, 0);   // r0 never hazards
    next_cycle(); load_use(5'd5, 5'd1); ifid_rt = 5'd5; ifid_uses_rt = 1'b1;
    expect_vec(O_LU, 0);
    next_cycle(); expect_vec(O_LU, 0);
    next_cycle(); load_use(5'd5, 5'd1); ifid_rt = 5'd5; expect_vec(O_RUN, 0); // rt unused
    next_cycle(); branch = 1; branch_neq = 1; is_equal = 1; expect_vec(O_RUN, 0); // bne not taken
    next_cycle(); jump = 1; expect_vec(O_JUMP, 0);
    next_cycle(); branch = 1; is_equal = 1; expect_vec(O_BR, 0);
    next_cycle(); ihit = 0; expect_vec(O_NOI, 0);
    for (int i = 0; i < 3; i++) begin                 // miss holds a taken branch
      next_cycle(); xmem_ren = 1; branch = 1; is_equal = 1; expect_vec(O_MWBR, 0);
    end
    next_cycle(); xmem_ren = 1; dhit = 1; branch = 1; is_equal = 1; expect_vec(O_BR, 0);
    next_cycle(); load_use(5'd8, 5'd8); expect_vec(O_LU, 0);
    next_cycle(); xmem_wen = 1; expect_vec(O_MW, 0);  // miss interrupts LDUSE
    next_cycle(); xmem_wen = 1; dhit = 1; expect_vec(O_LU, 0); // bubble resumes
    next_cycle(); expect_vec(O_RUN, 0);
    next_cycle(); load_use(5'd9, 5'd9); expect_vec(O_LU, 0);
    next_cycle(); branch = 1; is_equal = 1; expect_vec(O_BR, 0); // branch cancels LDUSE
    next_cycle(); expect_vec(O_RUN, 0);
    next_cycle(); xmem_halt = 1; expect_vec(O_HALT, 0);
    for (int i = 0; i < 12; i++) begin                // HALT absorbs everything
      next_cycle(); ihit = i[0];
      if (i == 5) xmem_ren = 1;
      if (i == 7) load_use(5'd3, 5'd3);
      expect_vec(O_HALT, 1'b1);
    end
    next_cycle(); nRST = 0; exp_sc = '0; expect_vec(O_RST, 1'b1);
    next_cycle(); nRST = 1; expect_vec(O_RUN, 0);
    next_cycle(); load_use(5'd8, 5'd8); expect_vec(O_LU, 0);
    next_cycle(); nRST = 0; exp_sc = '0; expect_vec(O_RST, 1'b1); // reset inside LDUSE
    next_cycle(); nRST = 1; expect_vec(O_RUN, 0);     // no bubble survives
    next_cycle(); expect_vec(O_RUN, 0);

    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge CLK);
    #1;
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard controller for the 5-stage A0 pipeline (IF/ID/EX/MEM/WB), replacing the bare hazard-unit interface with a stateful block. Detects load-use, branch/jump, instruction-fetch and data-cache-miss hazards, and halt. Drives per-stage stall/flush and PC enable. Holds a small FSM so multi-cycle load-use bubbles, cache-miss waits and halt drain are sequenced rather than re-derived combinationally each cycle.

## Interface
Parameters:
- REGW, 5, register-index width.
- LU_STALLS, 1, load-use bubble cycles (1..3), matching the datapath's load latency.
- PERFW, 32, width of the stall-cycle performance counter.

Ports:
- CLK  in  1  pipeline clock; one clock domain, all state on rising edge.
- nRST  in  1  asynchronous, active-low reset.
- ihit  in  1  instruction fetch complete this cycle.
- dhit  in  1  data access complete this cycle.
- xmem_ren, xmem_wen  in  1 each  MEM-stage data read/write request.
- xmem_halt  in  1  halt instruction in MEM.
- idex_memread  in  1  EX-stage instruction is a load.
- idex_rd  in  REGW  EX-stage destination register.
- ifid_rs, ifid_rt  in  REGW  ID-stage sources.
- ifid_uses_rt  in  1  ID instruction reads rt.
- branch, branch_neq, is_equal  in  1 each  EX-stage branch type and compare result.
- jump  in  1  ID-stage j/jal/jr.
- pc_en  out  1  PC update enable.
- stall_ifid, stall_idex, stall_xmem, stall_wb  out  1 each  hold the stage register.
- flush_ifid, flush_idex, flush_xmem, flush_wb  out  1 each  load a bubble into the stage register.
- take_branch  out  1  branch resolved taken.
- stall_count  out  PERFW  cycles in which pc_en=0, excluding HALT.

## Operation
- take_branch = branch & (is_equal ^ branch_neq).
- lu_hit = idex_memread & idex_rd≠0 & (idex_rd==ifid_rs | (ifid_uses_rt & idex_rd==ifid_rt)).
- mem_busy = (xmem_ren | xmem_wen) & ~dhit.
- States: RUN, LDUSE, MEMWAIT, HALT. Down-counter cnt, width clog2(LU_STALLS+1).
- Per-cycle priority:
  1. mem_busy
  2. xmem_halt
  3. take_branch
  4. jump
  5. lu_hit / LDUSE
  6. ~ihit
- mem_busy (any state except HALT):
  - Assert pc_en=0, stall_ifid/idex/xmem=1, flush_wb=1.
  - Enter or stay in MEMWAIT. Any pending branch, jump or load-use action is suppressed.
  - On the dhit cycle, return to RUN, or to LDUSE if cnt≠0. The deferred action then evaluates normally that same cycle.
- xmem_halt (not mem_busy):
  - Assert flush_ifid/idex/xmem=1 and pc_en=0, then enter HALT.
  - HALT is absorbing until nRST: pc_en=0, flush_ifid/idex/xmem=1, stall_wb=0.
- take_branch: flush_ifid=1, flush_idex=1, pc_en=1. Cancels a load-use stall; cnt is cleared.
- jump (no branch): flush_ifid=1, pc_en=1.
- lu_hit in RUN:
  - Assert pc_en=0, stall_ifid=1, flush_idex=1.
  - If LU_STALLS>1, load cnt=LU_STALLS-1 and enter LDUSE; otherwise stay in RUN.
- LDUSE: same outputs as lu_hit. cnt decrements each non-mem_busy cycle; go to RUN when cnt reaches 0.
- ~ihit with nothing higher: pc_en=0, flush_ifid=1; later stages advance.
- Otherwise: all stall/flush outputs 0, pc_en=1.
- stall_count increments when pc_en=0 and state≠HALT, wrapping at 2^PERFW.

## Timing
- All outputs are combinational from the current state, cnt and inputs. No added latency; decisions apply at the next CLK edge.
- State, cnt and stall_count update on CLK rising edge.
- A load-use on a load issued at cycle t yields exactly LU_STALLS cycles of pc_en=0, absent higher-priority events.
- While nRST=0, asynchronously:
  - state=RUN, cnt=0, stall_count=0.
  - Outputs forced: pc_en=0, flush_*=1, stall_*=0, take_branch=0.
- Deassertion mid-operation restarts cleanly from RUN. No partial LDUSE or MEMWAIT survives reset.
- Simultaneous mem_busy and take_branch: branch is held (EX stalled) and flushes on the dhit cycle.

## Structure
- cpu_types_pkg gains:
  - hzstate_t enum {RUN, LDUSE, MEMWAIT, HALT};
  - REGW constant;
  - regbits_t, reused for the register ports.
- hazard_unit_if is extended with take_branch, the LDUSE inputs and stall_count, with matching modports hzu and tb.
- No sub-module: one always_ff for state, cnt and stall_count, plus one always_comb for next-state and outputs.

## Test plan
- Load-use, LU_STALLS=2: idex_memread=1, idex_rd=8, ifid_rs=8, ihit=1 → pc_en=0, stall_ifid=1, flush_idex=1 for exactly 2 cycles, then pc_en=1; stall_count=2.
- Register zero: idex_rd=0=ifid_rs with idex_memread=1 → no stall.
- Cache miss with branch: xmem_ren=1, dhit=0 for 3 cycles, branch=1, is_equal=1 → stall_ifid/idex/xmem=1 and flush_wb=1 for 3 cycles. On the dhit cycle, flush_ifid=flush_idex=1 and take_branch=1.
- bne not taken: branch=1, branch_neq=1, is_equal=1 → take_branch=0 and no flush. Jump alone → flush_ifid=1 only.
- Halt: xmem_halt=1 → HALT. pc_en stays 0 for 10+ cycles regardless of ihit, and stall_count is frozen.
- Reset mid-LDUSE: assert nRST=0 asynchronously between edges → outputs are forced immediately. After release, the state is RUN with stall_count=0.
